// File: rtl/wave_player_pkg.sv
// Shared types and constants for the wavetable playback engine.
package wave_player_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SUM   = 2'd2
    } state_e;

    localparam int unsigned READ_LATENCY = 2;

    // Full-precision width of the voice sum: one growth bit per doubling of voices.
    function automatic int unsigned mix_width(input int unsigned num_osc,
                                              input int unsigned sample_width);
        return sample_width + $clog2(num_osc);
    endfunction

endpackage

// File: rtl/phase_accumulator.sv
// Per-voice fractional phase accumulator with wrap, force-to-0 and note-on retrigger.
module phase_accumulator #(
    parameter int unsigned WW_WIDTH   = 18,
    parameter int unsigned FRAC_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         clear,
    input  logic                         note_on,
    input  logic [WW_WIDTH+FRAC_WIDTH-1:0] step,
    input  logic [WW_WIDTH-1:0]          wave_width,
    output logic [WW_WIDTH-1:0]          index
);

    localparam int unsigned PW = WW_WIDTH + FRAC_WIDTH;

    logic [PW-1:0]       phase;
    logic                note_q;
    logic [WW_WIDTH-1:0] w_c;
    logic [WW_WIDTH:0]   w_ext_c;
    logic [PW:0]         sum_c;
    logic [PW:0]         wrap_c;
    logic [PW-1:0]       next_c;

    // One subtraction of the wave length; anything still out of range restarts at 0.
    always_comb begin
        w_c     = (wave_width == '0) ? WW_WIDTH'(1) : wave_width;
        w_ext_c = {1'b0, w_c};
        sum_c   = {1'b0, phase} + {1'b0, step};
        wrap_c  = sum_c - {1'b0, w_c, {FRAC_WIDTH{1'b0}}};
        next_c  = sum_c[PW-1:0];
        if (sum_c[PW:FRAC_WIDTH] >= w_ext_c) begin
            next_c = (wrap_c[PW:FRAC_WIDTH] >= w_ext_c) ? '0 : wrap_c[PW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase  <= '0;
            note_q <= 1'b0;
        end else begin
            note_q <= note_on;
            if (clear || (note_on && !note_q)) begin
                phase <= '0;
            end else if (tick) begin
                phase <= next_c;
            end
        end
    end

    assign index = phase[PW-1:FRAC_WIDTH];

endmodule

// File: rtl/wave_player.sv
// Wavetable playback engine: per-tick phase advance, BRAM latency wait and voice mix.
// WAVE_PLAYER_SATURATE_EN selects a saturating full-scale mix instead of the attenuated sum.
module wave_player
    import wave_player_pkg::*;
#(
    parameter int unsigned NUM_OSCILLATORS = 4,
    parameter int unsigned SAMPLE_WIDTH    = 16,
    parameter int unsigned WW_WIDTH        = 18,
    parameter int unsigned FRAC_WIDTH      = 8
) (
    input  logic                                                  clk_in,
    input  logic                                                  rst_in,
    input  logic                                                  sample_tick_in,
    input  logic [WW_WIDTH-1:0]                                   wave_width_in,
    input  logic                                                  ui_update_trig_in,
    input  logic [NUM_OSCILLATORS-1:0]                            note_on_in,
    input  logic [NUM_OSCILLATORS-1:0][WW_WIDTH+FRAC_WIDTH-1:0]   step_in,
    output logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]              osc_index_out,
    output logic [NUM_OSCILLATORS-1:0]                            osc_is_on_out,
    input  logic [NUM_OSCILLATORS-1:0][SAMPLE_WIDTH-1:0]          osc_data_in,
    output logic [SAMPLE_WIDTH-1:0]                               mix_out,
    output logic                                                  mix_valid_out,
    output logic                                                  busy_out,
    output logic                                                  tick_drop_out
);

    localparam int unsigned MIX_W = mix_width(NUM_OSCILLATORS, SAMPLE_WIDTH);
    localparam int unsigned SHIFT = $clog2(NUM_OSCILLATORS);
    localparam int unsigned CNT_W = $clog2(READ_LATENCY + 1);

`ifdef WAVE_PLAYER_SATURATE_EN
    localparam logic [SAMPLE_WIDTH-1:0] OUT_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic [SAMPLE_WIDTH-1:0] OUT_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
    localparam logic signed [MIX_W-1:0] SUM_MAX = MIX_W'($signed(OUT_MAX));
    localparam logic signed [MIX_W-1:0] SUM_MIN = MIX_W'($signed(OUT_MIN));
`endif

    state_e                                       state;
    state_e                                       next_state;
    logic [CNT_W-1:0]                             cnt;
    logic [NUM_OSCILLATORS-1:0]                   on_pend;
    logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0]     phase_index;
    logic                                         accept_c;
    logic                                         drop_c;
    logic                                         load_c;
    logic                                         fire_c;
    logic signed [MIX_W-1:0]                      acc_c;
    logic [SAMPLE_WIDTH-1:0]                      mix_c;

    for (genvar i = 0; i < NUM_OSCILLATORS; i++) begin : g_voice
        phase_accumulator #(
            .WW_WIDTH   (WW_WIDTH),
            .FRAC_WIDTH (FRAC_WIDTH)
        ) u_acc (
            .clk        (clk_in),
            .rst        (rst_in),
            .tick       (accept_c),
            .clear      (ui_update_trig_in),
            .note_on    (note_on_in[i]),
            .step       (step_in[i]),
            .wave_width (wave_width_in),
            .index      (phase_index[i])
        );
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (sample_tick_in) next_state = ST_FETCH;
            ST_FETCH: if (cnt == CNT_W'(READ_LATENCY)) next_state = ST_SUM;
            ST_SUM:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
        if (ui_update_trig_in) begin
            next_state = ST_IDLE;
        end
    end

    // The reload trigger overrides everything, including a coincident tick.
    always_comb begin
        accept_c = 1'b0;
        drop_c   = 1'b0;
        load_c   = 1'b0;
        fire_c   = 1'b0;
        accept_c = (state == ST_IDLE) && sample_tick_in && !ui_update_trig_in;
        drop_c   = (state != ST_IDLE) && sample_tick_in;
        load_c   = (state == ST_FETCH) && (cnt == '0) && !ui_update_trig_in;
        fire_c   = (state == ST_SUM) && !ui_update_trig_in;
    end

    // Disabled voices contribute nothing, whatever their BRAM is still presenting.
    always_comb begin
        acc_c = '0;
        mix_c = '0;
        for (int i = 0; i < NUM_OSCILLATORS; i++) begin
            if (osc_is_on_out[i]) begin
                acc_c = acc_c + MIX_W'($signed(osc_data_in[i]));
            end
        end
`ifdef WAVE_PLAYER_SATURATE_EN
        if (acc_c > SUM_MAX) begin
            mix_c = OUT_MAX;
        end else if (acc_c < SUM_MIN) begin
            mix_c = OUT_MIN;
        end else begin
            mix_c = SAMPLE_WIDTH'(acc_c);
        end
`else
        mix_c = SAMPLE_WIDTH'(acc_c >>> SHIFT);
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt           <= '0;
            on_pend       <= '0;
            osc_index_out <= '0;
            osc_is_on_out <= '0;
            mix_out       <= '0;
            mix_valid_out <= 1'b0;
            busy_out      <= 1'b0;
            tick_drop_out <= 1'b0;
        end else begin
            busy_out      <= (state != ST_IDLE);
            tick_drop_out <= drop_c;
            mix_valid_out <= fire_c;
            if (fire_c) begin
                mix_out <= mix_c;
            end
            if (accept_c) begin
                on_pend <= note_on_in;
            end
            if (ui_update_trig_in) begin
                osc_is_on_out <= '0;
            end else if (load_c) begin
                osc_is_on_out <= on_pend;
                osc_index_out <= phase_index;
            end
            if ((state == ST_FETCH) && (next_state == ST_FETCH)) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wave_player.sv
// Self-checking bench for wave_player against an arithmetic phase/mix model and a 2-cycle BRAM model.
module tb_wave_player;

    localparam int unsigned N  = 4;
    localparam int unsigned SW = 16;
    localparam int unsigned WW = 18;
    localparam int unsigned FW = 8;
    localparam int unsigned PW = WW + FW;

    logic                    clk_in;
    logic                    rst_in;
    logic                    sample_tick_in;
    logic [WW-1:0]           wave_width_in;
    logic                    ui_update_trig_in;
    logic [N-1:0]            note_on_in;
    logic [N-1:0][PW-1:0]    step_in;
    logic [N-1:0][WW-1:0]    osc_index_out;
    logic [N-1:0]            osc_is_on_out;
    logic [N-1:0][SW-1:0]    osc_data_in;
    logic [N-1:0][SW-1:0]    bram_q1;
    logic [SW-1:0]           mix_out;
    logic                    mix_valid_out;
    logic                    busy_out;
    logic                    tick_drop_out;

    int checks = 0;
    int errors = 0;

    int           mode [N];
    logic [SW-1:0] cval [N];
    longint       ph   [N];

    typedef struct {
        logic [N-1:0][WW-1:0] idx;
        logic [N-1:0][WW-1:0] exp_idx;
        logic [N-1:0]         on;
        logic [SW-1:0]        mix;
        logic [SW-1:0]        exp_mix;
        int                   k;
        bit                   drop;
    } pass_t;

    wave_player #(
        .NUM_OSCILLATORS (N),
        .SAMPLE_WIDTH    (SW),
        .WW_WIDTH        (WW),
        .FRAC_WIDTH      (FW)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .sample_tick_in    (sample_tick_in),
        .wave_width_in     (wave_width_in),
        .ui_update_trig_in (ui_update_trig_in),
        .note_on_in        (note_on_in),
        .step_in           (step_in),
        .osc_index_out     (osc_index_out),
        .osc_is_on_out     (osc_is_on_out),
        .osc_data_in       (osc_data_in),
        .mix_out           (mix_out),
        .mix_valid_out     (mix_valid_out),
        .busy_out          (busy_out),
        .tick_drop_out     (tick_drop_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [SW-1:0] bram_val(input int i, input logic [WW-1:0] idx);
        if (mode[i] == 0) return SW'(idx * 100);
        return cval[i];
    endfunction

    // BRAM with registered output: address in, data two edges later.
    always @(posedge clk_in) begin
        for (int i = 0; i < N; i++) begin
            bram_q1[i]     <= bram_val(i, osc_index_out[i]);
            osc_data_in[i] <= bram_q1[i];
        end
    end

    function automatic void model_tick(input logic [N-1:0] rise);
        longint w;
        longint nxt;
        w = (wave_width_in == 0) ? 64'sd1 : longint'(wave_width_in);
        for (int i = 0; i < N; i++) begin
            if (rise[i]) begin
                ph[i] = 0;
            end else begin
                nxt = ph[i] + longint'(step_in[i]);
                if ((nxt >> FW) >= w) nxt = nxt - (w << FW);
                if ((nxt >> FW) >= w) nxt = 0;
                ph[i] = nxt;
            end
        end
    endfunction

    function automatic logic [SW-1:0] model_mix(input logic [N-1:0] notes,
                                                input logic [N-1:0][WW-1:0] idx);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) begin
            if (notes[i]) s = s + int'($signed(bram_val(i, idx[i])));
        end
`ifdef WAVE_PLAYER_SATURATE_EN
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return SW'(s);
`else
        return SW'(s >>> $clog2(N));
`endif
    endfunction

    // Called at a falling edge; issues one tick and returns at the falling edge the mix appears.
    task automatic run_pass(input logic [N-1:0] notes, output pass_t p);
        logic [N-1:0] rise;
        rise           = notes & ~note_on_in;
        note_on_in     = notes;
        sample_tick_in = 1'b1;
        model_tick(rise);
        for (int i = 0; i < N; i++) p.exp_idx[i] = WW'(ph[i] >> FW);
        p.exp_mix = model_mix(notes, p.exp_idx);
        p.k    = -1;
        p.drop = 1'b0;
        p.idx  = '0;
        p.on   = '0;
        p.mix  = '0;
        @(posedge clk_in);
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        for (int k = 1; k <= 12 && p.k < 0; k++) begin
            @(negedge clk_in);
            if (k == 1) begin
                p.idx = osc_index_out;
                p.on  = osc_is_on_out;
            end
            if (tick_drop_out) p.drop = 1'b1;
            if (mix_valid_out) begin
                p.k   = k;
                p.mix = mix_out;
            end
        end
    endtask

    task automatic pulse_trig;
        ui_update_trig_in = 1'b1;
        @(negedge clk_in);
        ui_update_trig_in = 1'b0;
        for (int i = 0; i < N; i++) ph[i] = 0;
    endtask

    task automatic test_reset;
        int vcnt;
        checks++;
        if (osc_index_out !== '0 || osc_is_on_out !== '0) begin
            errors++;
            $display("FAIL reset_osc: index %h on %b, want 0", osc_index_out, osc_is_on_out);
        end
        checks++;
        if (mix_out !== '0 || mix_valid_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mix: mix %h valid %b, want 0", mix_out, mix_valid_out);
        end
        checks++;
        if (busy_out !== 1'b0 || tick_drop_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy %b drop %b, want 0", busy_out, tick_drop_out);
        end
        wave_width_in = 8;
        step_in[0]    = PW'(32'h100);
        note_on_in    = 4'b0001;
        @(negedge clk_in);
        sample_tick_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        for (int i = 0; i < N; i++) ph[i] = 0;
        vcnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_in);
            if (mix_valid_out) vcnt++;
            if (k == 0) begin
                checks++;
                if (busy_out !== 1'b0 || osc_is_on_out !== '0 || osc_index_out !== '0) begin
                    errors++;
                    $display("FAIL reset_midpass: busy %b on %b index %h, want 0",
                             busy_out, osc_is_on_out, osc_index_out);
                end
            end
        end
        checks++;
        if (vcnt != 0) begin
            errors++;
            $display("FAIL reset_no_pulse: %0d mix pulses, want 0", vcnt);
        end
    endtask

    task automatic test_wrap;
        pass_t p;
        int want [5] = '{1, 2, 3, 0, 1};
        int wmix [5] = '{25, 50, 75, 0, 25};
        int wm;
        pulse_trig();
        wave_width_in = 4;
        step_in       = '0;
        step_in[0]    = PW'(32'h100);
        for (int i = 0; i < N; i++) mode[i] = 0;
        @(negedge clk_in);
        for (int j = 0; j < 5; j++) begin
            run_pass(4'b0001, p);
`ifdef WAVE_PLAYER_SATURATE_EN
            wm = wmix[j] * 4;
`else
            wm = wmix[j];
`endif
            checks++;
            if (p.idx[0] !== WW'(want[j]) || p.idx !== p.exp_idx) begin
                errors++;
                $display("FAIL wrap_index[%0d]: got %h want %h", j, p.idx, p.exp_idx);
            end
            checks++;
            if (p.mix !== SW'(wm) || p.mix !== p.exp_mix) begin
                errors++;
                $display("FAIL wrap_mix[%0d]: got %0d want %0d", j, p.mix, wm);
            end
            checks++;
            if (p.k != 4 || p.on !== 4'b0001) begin
                errors++;
                $display("FAIL wrap_timing[%0d]: latency %0d on %b, want 4 / 0001", j, p.k, p.on);
            end
        end
        @(negedge clk_in);
        checks++;
        if (mix_valid_out !== 1'b0 || mix_out !== p.mix) begin
            errors++;
            $display("FAIL mix_hold: valid %b mix %h, want 0 / %h", mix_valid_out, mix_out, p.mix);
        end
    endtask

    task automatic test_frac;
        pass_t p;
        int want [6] = '{1, 3, 4, 6, 7, 1};
        pulse_trig();
        wave_width_in = 8;
        step_in[0]    = PW'(32'h180);
        for (int j = 0; j < 6; j++) begin
            run_pass(4'b0001, p);
            checks++;
            if (p.idx[0] !== WW'(want[j]) || p.idx !== p.exp_idx) begin
                errors++;
                $display("FAIL frac_index[%0d]: got %h want %0d", j, p.idx, want[j]);
            end
        end
    endtask

    task automatic test_scaling;
        pass_t p;
        logic [SW-1:0] want;
        pulse_trig();
        for (int i = 0; i < N; i++) mode[i] = 1;
        cval[0] = 16'h7FFF;
        cval[1] = 16'h7FFF;
        cval[2] = 16'h1234;
        cval[3] = 16'h1234;
`ifdef WAVE_PLAYER_SATURATE_EN
        want = 16'h7FFF;
`else
        want = 16'h3FFF;
`endif
        run_pass(4'b0011, p);
        checks++;
        if (p.mix !== want || p.mix !== p.exp_mix) begin
            errors++;
            $display("FAIL scaling_mix: got %h want %h", p.mix, want);
        end
        checks++;
        if (p.on !== 4'b0011) begin
            errors++;
            $display("FAIL scaling_enable: got %b want 0011", p.on);
        end
    endtask

    task automatic test_retrigger;
        pass_t p;
        pulse_trig();
        wave_width_in = 64;
        for (int i = 0; i < N; i++) step_in[i] = PW'((i + 1) * 32'h100);
        for (int i = 0; i < N; i++) mode[i] = 0;
        run_pass(4'b0001, p);
        run_pass(4'b0001, p);
        run_pass(4'b0011, p);
        checks++;
        if (p.idx[1] !== WW'(0) || p.idx !== p.exp_idx) begin
            errors++;
            $display("FAIL retrig_index: got %h want %h", p.idx, p.exp_idx);
        end
        run_pass(4'b0011, p);
        checks++;
        if (p.idx[1] !== WW'(2) || p.idx !== p.exp_idx || p.mix !== p.exp_mix) begin
            errors++;
            $display("FAIL retrig_advance: got %h/%h want %h/%h", p.idx, p.mix, p.exp_idx, p.exp_mix);
        end
    endtask

    task automatic test_overrun;
        logic [N-1:0][WW-1:0] eidx;
        logic [SW-1:0]        emix;
        logic [4:0]           busy_hist;
        int                   vcnt;
        int                   vk;
        pulse_trig();
        wave_width_in = 16;
        step_in       = '0;
        step_in[0]    = PW'(32'h100);
        sample_tick_in = 1'b1;
        model_tick('0);
        for (int i = 0; i < N; i++) eidx[i] = WW'(ph[i] >> FW);
        emix = model_mix(note_on_in, eidx);
        busy_hist = '0;
        vcnt = 0;
        vk   = -1;
        @(posedge clk_in);
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_in);
            if (k <= 5) busy_hist[k-1] = busy_out;
            if (mix_valid_out) begin
                vcnt++;
                vk = k;
            end
            if (k == 1) begin
                checks++;
                if (tick_drop_out !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_early: got %b want 0", tick_drop_out);
                end
                sample_tick_in = 1'b1;
            end else if (k == 2) begin
                sample_tick_in = 1'b0;
                checks++;
                if (tick_drop_out !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_pulse: got %b want 1", tick_drop_out);
                end
            end else if (k == 3) begin
                checks++;
                if (tick_drop_out !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_width: got %b want 0", tick_drop_out);
                end
            end
        end
        checks++;
        if (vcnt != 1 || vk != 4 || mix_out !== emix) begin
            errors++;
            $display("FAIL overrun_mix: %0d pulses at %0d mix %h, want 1 at 4 mix %h", vcnt, vk, mix_out, emix);
        end
        checks++;
        if (busy_hist !== 5'b01111) begin
            errors++;
            $display("FAIL busy_window: got %b want 01111", busy_hist);
        end
    endtask

    task automatic test_abort;
        pass_t p;
        int    vcnt;
        wave_width_in = 8;
        step_in[0]    = PW'(32'h100);
        sample_tick_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        sample_tick_in = 1'b0;
        vcnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_in);
            if (mix_valid_out) vcnt++;
            if (k == 1) ui_update_trig_in = 1'b1;
            if (k == 2) begin
                ui_update_trig_in = 1'b0;
                for (int i = 0; i < N; i++) ph[i] = 0;
            end
            if (k == 3) begin
                checks++;
                if (busy_out !== 1'b0 || osc_is_on_out !== '0) begin
                    errors++;
                    $display("FAIL abort_state: busy %b on %b, want 0", busy_out, osc_is_on_out);
                end
            end
        end
        checks++;
        if (vcnt != 0) begin
            errors++;
            $display("FAIL abort_pulse: %0d pulses, want 0", vcnt);
        end
        step_in[0] = PW'(32'h300);
        run_pass(4'b0001, p);
        checks++;
        if (p.idx[0] !== WW'(3) || p.idx !== p.exp_idx) begin
            errors++;
            $display("FAIL abort_restart: got %h want 3", p.idx[0]);
        end
    endtask

    task automatic test_shrink;
        pass_t p;
        pulse_trig();
        wave_width_in = 16;
        step_in[0]    = PW'(32'hA00);
        run_pass(4'b0001, p);
        checks++;
        if (p.idx[0] !== WW'(10)) begin
            errors++;
            $display("FAIL shrink_setup: got %0d want 10", p.idx[0]);
        end
        wave_width_in = 4;
        step_in[0]    = PW'(32'h100);
        run_pass(4'b0001, p);
        checks++;
        if (p.idx[0] !== WW'(0) || p.idx !== p.exp_idx) begin
            errors++;
            $display("FAIL shrink_force0: got %h want %h", p.idx, p.exp_idx);
        end
    endtask

    task automatic test_back_to_back;
        pass_t p;
        logic [N-1:0] notes;
        for (int j = 0; j < 40; j++) begin
            wave_width_in = WW'($urandom_range(0, 48));
            for (int i = 0; i < N; i++) begin
                step_in[i] = PW'($urandom_range(0, 32'h4000));
                if ($urandom_range(0, 7) == 0) step_in[i] = PW'($urandom);
                mode[i] = int'($urandom_range(0, 1));
                cval[i] = SW'($urandom);
            end
            notes = N'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk_in);
            run_pass(notes, p);
            checks++;
            if (p.idx !== p.exp_idx || p.on !== notes) begin
                errors++;
                $display("FAIL rand_index[%0d]: got %h/%b want %h/%b", j, p.idx, p.on, p.exp_idx, notes);
            end
            checks++;
            if (p.mix !== p.exp_mix || p.k != 4 || p.drop) begin
                errors++;
                $display("FAIL rand_mix[%0d]: got %h lat %0d drop %b want %h lat 4 drop 0",
                         j, p.mix, p.k, p.drop, p.exp_mix);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in            = 1'b1;
        sample_tick_in    = 1'b0;
        ui_update_trig_in = 1'b0;
        wave_width_in     = '0;
        note_on_in        = '0;
        step_in           = '0;
        for (int i = 0; i < N; i++) begin
            mode[i] = 0;
            cval[i] = '0;
            ph[i]   = 0;
        end
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        test_reset();
        test_wrap();
        test_frac();
        test_scaling();
        test_retrigger();
        test_overrun();
        test_abort();
        test_shrink();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_player.md
# wave_player

Playback engine on the read side of the per-oscillator wavetable BRAMs, which the wave loader fills from main memory. On each audio sample strobe it advances one fractional phase accumulator per oscillator and drives the playback index and read enable to that oscillator's BRAM. It then absorbs the BRAM read latency, sums the returned samples of the active oscillators, and emits one mixed sample per strobe to the audio output path.

## Interface
Parameters:
- NUM_OSCILLATORS, 4: number of voices; must be a power of two, at least 1.
- SAMPLE_WIDTH, 16: sample width, signed two's complement.
- WW_WIDTH, 18: wave-width and index width.
- FRAC_WIDTH, 8: fractional phase bits.

Ports:
- clk_in  in  1  system clock; one clock domain.
- rst_in  in  1  reset, synchronous and active-high.
- sample_tick_in  in  1  one-cycle audio sample strobe.
- wave_width_in  in  WW_WIDTH  current wave length in samples.
- ui_update_trig_in  in  1  wavetable reload strobe; the same strobe the loader receives.
- note_on_in  in  NUM_OSCILLATORS  per-voice gate.
- step_in  in  [WW_WIDTH+FRAC_WIDTH-1:0] x NUM_OSCILLATORS  phase increment per tick, unsigned fixed point.
- osc_index_out  out  WW_WIDTH x NUM_OSCILLATORS  BRAM read address (port B).
- osc_is_on_out  out  NUM_OSCILLATORS  BRAM port-B enable.
- osc_data_in  in  SAMPLE_WIDTH x NUM_OSCILLATORS  BRAM read data; 2-cycle read latency, registered output.
- mix_out  out  SAMPLE_WIDTH  mixed sample.
- mix_valid_out  out  1  one-cycle pulse; mix_out is valid while it is high.
- busy_out  out  1  a pass is in progress.
- tick_drop_out  out  1  one-cycle pulse when a tick arrives while busy.

## Operation
- States: IDLE, FETCH (2-cycle wait counter), SUM.
- IDLE + sample_tick_in:
  - Update each phase: next = phase + step.
  - If the integer part of next ≥ W, subtract W<<FRAC_WIDTH once.
  - If it is still ≥ W, force next to 0.
  - W = max(wave_width_in, 1).
  - Load osc_index_out[i] with the integer part of next.
  - Latch osc_is_on_out from note_on_in.
  - Go to FETCH.
- FETCH: hold addresses and enables for 2 cycles, then go to SUM.
- SUM:
  - Sum osc_data_in[i] sign-extended to SAMPLE_WIDTH+log2(NUM_OSCILLATORS) bits.
  - Voices with the latched enable at 0 contribute 0; stale BRAM output is never used.
  - Scale per Configuration, register to mix_out, pulse mix_valid_out, return to IDLE.
- Rising edge of note_on_in[i]: phase[i] becomes 0. If it coincides with an accepted tick, the reset wins and phase[i] is not advanced on that tick.
- wave_width_in shrinking below the current index: handled by the wrap rule on the next tick; the index is never ≥ W after any tick.
- ui_update_trig_in:
  - All phases become 0.
  - Any pass in progress aborts to IDLE with no mix_valid_out pulse.
  - osc_is_on_out clears.
  - A trigger arriving together with a tick also suppresses that tick.
- A tick in FETCH or SUM is dropped and tick_drop_out pulses. Pass state is unaffected.
- mix_out holds its value between pulses.

## Timing
- Reset values:
  - All outputs are 0.
  - All phases are 0.
  - State is IDLE.
  - Reset mid-pass aborts the pass with no pulse.
- Tick sampled at edge T:
  - osc_index_out and osc_is_on_out update at edge T+1.
  - BRAM data is valid after edge T+3 and is summed at edge T+4.
  - mix_valid_out is high for exactly one cycle after edge T+4.
- busy_out is high after edges T+1 through T+4.
- Ticks at edges T+1 through T+4 are dropped. The next tick can be accepted at edge T+5, so the minimum tick spacing is 5 cycles.
- tick_drop_out is registered: high for the cycle after the edge that sampled the dropped tick.

## Configuration
- Macro: WAVE_PLAYER_SATURATE_EN.
- Defined: the full-width sum is saturated to the signed SAMPLE_WIDTH range, with no attenuation.
- Undefined: the sum is arithmetic-shifted right by log2(NUM_OSCILLATORS); overflow is impossible.

## Structure
- Package wave_player_pkg holds:
  - the state enum;
  - the READ_LATENCY = 2 constant;
  - a MIX_WIDTH function of NUM_OSCILLATORS and SAMPLE_WIDTH.
- Sub-module phase_accumulator, one per voice via generate, owns:
  - the phase register;
  - the step add;
  - the wrap and force-to-0 rule;
  - the note-on retrigger.
- The top level owns the FSM, the wait counter and the mixer.

## Test plan
- Wrap at step 1.0: W=4, step 0x100, voice 0 on, BRAM model data = index*100, five ticks -> indices 1,2,3,0,1; mixes (no macro) 25,50,75,0,25.
- Fractional step: W=8, step 0x180, six ticks -> indices 1,3,4,6,7,1.
- Mix scaling: voices 0 and 1 both return 0x7FFF, voices 2 and 3 off with their BRAM output 0x1234 -> mix 0x3FFF without the macro, 0x7FFF with WAVE_PLAYER_SATURATE_EN.
- Overrun: ticks at edges T and T+2 -> tick_drop_out high after edge T+2, a single mix_valid_out after edge T+4.
- Abort: ui_update_trig_in at edge T+2 mid-pass -> no mix_valid_out, busy_out low after edge T+3. The next tick with step 0x300 -> index 3.
- Width shrink: index 10 at W=16, then W=4 with step 0x100 -> the next tick yields index 0 (11-4=7 is still ≥ 4, so forced to 0).
